// File: rtl/sha256_compress_core_if.sv
// sha256_compress_core_if: request/response bundle between a block source and the compression core.
interface sha256_compress_core_if;
  logic         Start;
  logic         Init;
  logic         Mode224;
  logic [511:0] Block;
  logic         Ready;
  logic         Busy;
  logic         Done;
  logic [255:0] Digest;
  modport master (output Start, Init, Mode224, Block, input Ready, Busy, Done, Digest);
  modport slave  (input Start, Init, Mode224, Block, output Ready, Busy, Done, Digest);
endinterface

// File: rtl/sha256_compress_core.sv
// sha256_compress_core: iterative SHA-256/224 compression, UNROLL rounds per clock.
module sha256_compress_core #(
  parameter int UNROLL = 1
) (
  input logic Clk,
  input logic Reset,
  sha256_compress_core_if.slave bus
);
  typedef logic [0:7][31:0]  st_t;
  typedef logic [0:15][31:0] win_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
    $error("UNROLL must be 1, 2, 4, 8 or 16");
  end
  localparam st_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam st_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                           32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction
  function automatic st_t rnd(input st_t s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] t1, t2;
    t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  endfunction
  // Rounds t..t+UNROLL-1 consume the first UNROLL words of the current window.
  function automatic st_t rounds(input st_t s, input win_t w, input logic [5:0] t);
    st_t r;
    r = s;
    for (int j = 0; j < UNROLL; j++) r = rnd(r, K[t + 6'(j)], w[j]);
    return r;
  endfunction
  // Each new word feeds the next, so UNROLL=16 chains all sixteen in one cycle.
  function automatic win_t sched(input win_t w);
    win_t x;
    logic [31:0] nw;
    x = w;
    for (int j = 0; j < UNROLL; j++) begin
      nw = ssig1(x[14]) + x[9] + ssig0(x[1]) + x[0];
      x = {x[1:15], nw};
    end
    return x;
  endfunction
  function automatic st_t add8(input st_t a, input st_t b);
    st_t r;
    for (int i = 0; i < 8; i++) r[i] = a[i] + b[i];
    return r;
  endfunction
  state_t state;
  logic [5:0] t;
  st_t v, chain, digest, sel, v_nx, sum;
  win_t w, w_nx;
  logic m224, ready, busy, done;
  assign sel = !bus.Init ? chain : bus.Mode224 ? IV224 : IV256;
  assign v_nx = rounds(v, w, t);
  assign w_nx = sched(w);
  assign sum = add8(chain, v);
  assign bus.Ready = ready;
  assign bus.Busy = busy;
  assign bus.Done = done;
  assign bus.Digest = digest;
  // The chain register takes the selected start value on accept, so FINAL only needs chain + v.
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      t <= '0;
      v <= '0;
      w <= '0;
      chain <= '0;
      digest <= '0;
      m224 <= 1'b0;
      ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.Start) begin
          w <= bus.Block;
          m224 <= bus.Mode224;
          chain <= sel;
          v <= sel;
          t <= '0;
          ready <= 1'b0;
          busy <= 1'b1;
          state <= ROUND;
        end
        ROUND: begin
          v <= v_nx;
          w <= w_nx;
          t <= t + 6'(UNROLL);
          if (7'(t) + 7'(UNROLL) == 7'd64) state <= FINAL;
        end
        FINAL: begin
          chain <= sum;
          digest <= m224 ? {sum[0:6], 32'h0} : sum;
          done <= 1'b1;
          ready <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/sha256_compress_core.md
# sha256_compress_core

Iterative SHA-256/SHA-224 compression engine that processes one 512-bit padded message block per request. It contains the message schedule, the round-constant ROM, and the chaining-value registers and final addition. `UNROLL` rounds are evaluated combinationally per clock, trading area against latency. It sits between the UART block assembler and the digest serialiser, and replaces the single-round datapath stage.

## Interface
Parameters:
- `UNROLL`, default 1: rounds per clock. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports (reset is `Reset`, asynchronous, active-low; clock is `Clk`):
- `Clk`  in  1  system clock, rising-edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request pulse; accepted only when `Ready`=1.
- `Init`  in  1  sampled with `Start`. 1 = chain from IV (first block); 0 = chain from previous result.
- `Mode224`  in  1  sampled with `Start`. 1 = SHA-224 IV and output truncation.
- `Block`  in  512  padded block, big-endian; `Block[511:480]` = W0. Sampled with `Start`.
- `Ready`  out  1  engine idle, `Start` will be accepted.
- `Busy`  out  1  compression in progress.
- `Done`  out  1  one-cycle pulse when `Digest` updates.
- `Digest`  out  256  H0 in `[255:224]` … H7 in `[31:0]`. In SHA-224 mode `[31:0]` reads 0.

## Operation
- States:
  - IDLE: `Ready`=1.
  - ROUND: `Busy`=1, round counter `t` advances by `UNROLL`.
  - FINAL: add the working variables to the chain value.
  - Transitions: IDLE→ROUND on accepted `Start`; ROUND→FINAL when `t`+`UNROLL`=64; FINAL→IDLE unconditionally.
- On accept:
  - Load the 16-word schedule window from `Block`.
  - Latch `Mode224`.
  - Select the chain value: SHA-256 IV (6a09e667 … 5be0cd19), SHA-224 IV (c1059ed8 … befa4fa4), or the internal 256-bit chain register (`Init`=0).
  - Load working variables a..h from the selected chain value; `t`=0.
- Round function per round, all arithmetic mod 2^32 with carries discarded:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t].
  - T2 = Σ0(a) + Maj(a,b,c).
  - a←T1+T2, e←d+T1; the other variables shift down.
- Schedule:
  - Rounds 0..15 consume the window directly.
  - For t≥16: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - The window shifts by `UNROLL` words per cycle. For `UNROLL`=16, all 16 new words are computed in one cycle, chained combinationally.
- K ROM: 64×32 constant table, indexed `t`..`t`+`UNROLL`-1.
- FINAL:
  - chain[i] ← chain_sel[i] + var[i] for all 8 words.
  - `Digest` ← the new chain, with `[31:0]` masked to 0 when the latched `Mode224`=1.
  - The internal chain always keeps the full H7.
- `Start` while `Busy`=1 is ignored: no state change, `Block` is not sampled.
- `Init`=0 after reset chains from the all-zero chain register. This is defined behaviour, not an error.

## Timing
- Reset values: `Ready`=1, `Busy`=0, `Done`=0, `Digest`=0, chain register=0, state=IDLE, `t`=0.
- Accept at edge E0. `Busy`=1 for cycles 1..64/`UNROLL`+1, which covers the ROUND cycles plus FINAL.
- `Done`=1 and the new `Digest` appear together after edge E0+64/`UNROLL`+1. `Ready`=1 in that same cycle.
  - Latency: 65 cycles at `UNROLL`=1, 17 at 4, 5 at 16.
- Back-to-back: `Start` asserted in the `Done` cycle is accepted. With `Init`=0 it chains from the digest just produced. Throughput is one block per 64/`UNROLL`+1 cycles.
- `Digest` holds its value until the next `Done`. It does not change while `Busy`.
- Reset asserted mid-operation: the engine returns to IDLE immediately. Outputs and chain revert to reset values, no `Done` is issued, and the in-flight block is lost.

## Test plan
- SHA-256 "abc": `Block`=61626380, fourteen words of 0, then 00000018; `Init`=1, `Mode224`=0 → `Digest`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. `Done` must arrive exactly 65 cycles after accept (`UNROLL`=1) and 17 cycles after accept (`UNROLL`=4).
- SHA-224 "abc": same block, `Mode224`=1 → `Digest[255:32]`=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7; `Digest[31:0]`=0.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Block 1 with `Init`=1; block 2 with `Init`=0, started in block 1's `Done` cycle.
  - Final `Digest`=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - No idle gap between blocks.
- Empty message: `Block`=80000000 followed by zeros → `Digest`=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
  - Repeat with `UNROLL` ∈ {1, 2, 8, 16}; every setting must produce an identical digest.
- Ignored start and mid-run reset:
  - Pulse `Start` with a different `Block` at cycle 10 of a run → digest unchanged.
  - Drop `Reset` at cycle 20 → `Busy`=0, `Ready`=1, `Digest`=0 immediately, and no `Done` afterwards.
  - Then `Init`=0 with "abc" → the digest equals the compression of the block from a zero chain; compare against the reference model.
